// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_pkg
//  Brief    : Shared widths, opcode constants, FSM encoding and helpers for
//             the MIPS32 instruction fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
package ifu_pkg;

    localparam int WORD_LEN   = 32;
    localparam int OPCODE_LEN = 6;
    localparam int FUNCT_LEN  = 6;

    // Opcodes the fetch unit cares about (the rest are decoded downstream)
    localparam logic [OPCODE_LEN-1:0] c_OP_RTYPE = 6'h00;
    localparam logic [OPCODE_LEN-1:0] c_OP_J     = 6'h02;
    localparam logic [OPCODE_LEN-1:0] c_OP_BEQ   = 6'h04;

    // Fetch/execute sequencer encoding
    typedef enum logic [0:0] {
        IFU_FETCH = 1'b0,
        IFU_EXEC  = 1'b1
    } ifu_state_e;

    // Sign-extend a 16-bit immediate to a full word
    function automatic logic [WORD_LEN-1:0] sign_ext16(input logic [15:0] imm);
        return {{(WORD_LEN-16){imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_npc
//  Brief    : Combinational next-PC selection: jump target, taken branch
//             target or sequential PC+4. Jump has priority over branch.
//  Revision : 1.0  initial release
// ============================================================================
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [WORD_LEN-1:0] i_pc_plus4,
    input  logic [25:0]         i_target,   // Instr[25:0]; imm is its low half
    input  logic                i_jump,
    input  logic                i_branch,
    input  logic                i_zero,
    output logic [WORD_LEN-1:0] o_next_pc
);

    logic [WORD_LEN-1:0] w_imm_sext;
    logic [WORD_LEN-1:0] w_br_off;

    assign w_imm_sext = sign_ext16(i_target[15:0]);
    assign w_br_off   = {w_imm_sext[WORD_LEN-3:0], 2'b00};

    // Priority select of the next PC; low two bits always forced to zero
    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump) begin
            o_next_pc = {i_pc_plus4[31:28], i_target, 2'b00};
        end else if (i_branch && i_zero) begin
            o_next_pc = i_pc_plus4 + w_br_off;
        end
        o_next_pc[1:0] = 2'b00;
    end

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ifu
//  Brief    : MIPS32 instruction fetch unit. Holds the PC, fetches one word
//             per instruction over a req/valid handshake, latches it in the
//             instruction register and resolves the next PC when the
//             instruction leaves EXEC.
//  Revision : 1.0  initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter logic [WORD_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Jump,
    input  logic                  Branch,
    input  logic                  Zero,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [WORD_LEN-1:0]   imem_addr,
    input  logic [WORD_LEN-1:0]   imem_rdata,
    input  logic                  imem_valid,
    output logic [WORD_LEN-1:0]   Instr,
    output logic                  InstrValid,
    output logic [OPCODE_LEN-1:0] OpCode,
    output logic [FUNCT_LEN-1:0]  Funct,
    output logic [WORD_LEN-1:0]   PC,
    output logic [WORD_LEN-1:0]   PCPlus4,
    output logic [WORD_LEN-1:0]   InstrCount
);

    // A misaligned reset vector is silently aligned down
    localparam logic [WORD_LEN-1:0] c_RESET_PC_ALIGNED = {RESET_PC[WORD_LEN-1:2], 2'b00};

    ifu_state_e          r_state_q, w_state_d;
    logic [WORD_LEN-1:0] r_pc_q,    w_pc_d;
    logic [WORD_LEN-1:0] r_instr_q, w_instr_d;
    logic [WORD_LEN-1:0] r_count_q, w_count_d;
    logic [WORD_LEN-1:0] w_pc_plus4;
    logic [WORD_LEN-1:0] w_next_pc;

    assign w_pc_plus4 = r_pc_q + 32'd4;

    ifu_npc u_npc (
        .i_pc_plus4 (w_pc_plus4),
        .i_target   (r_instr_q[25:0]),
        .i_jump     (Jump),
        .i_branch   (Branch),
        .i_zero     (Zero),
        .o_next_pc  (w_next_pc)
    );

    // Next-state and register update: latch on valid in FETCH, retire in EXEC
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_count_d = r_count_q;
        case (r_state_q)
            IFU_FETCH: begin
                if (imem_valid) begin
                    w_instr_d = imem_rdata;
                    w_state_d = IFU_EXEC;
                end
            end
            IFU_EXEC: begin
                if (!stall) begin
                    w_pc_d    = w_next_pc;
                    w_count_d = r_count_q + 32'd1;
                    w_state_d = IFU_FETCH;
                end
            end
            default: w_state_d = IFU_FETCH;
        endcase
    end

    // State registers; reset overrides stall and any memory response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IFU_FETCH;
            r_pc_q    <= c_RESET_PC_ALIGNED;
            r_instr_q <= '0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_count_q <= w_count_d;
        end
    end

    // Handshake and status outputs are held low while rst is asserted
    assign imem_req   = !rst && (r_state_q == IFU_FETCH);
    assign InstrValid = !rst && (r_state_q == IFU_EXEC);
    assign imem_addr  = r_pc_q;
    assign PC         = r_pc_q;
    assign PCPlus4    = w_pc_plus4;
    assign Instr      = r_instr_q;
    assign OpCode     = r_instr_q[31:26];
    assign Funct      = r_instr_q[5:0];
    assign InstrCount = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu
//  Brief    : Directed self-checking bench for ifu. Three instances share
//             all stimulus and differ only in reset vector (0x3000,
//             0xF000_0010, 0xFFFF_FFFC) so jump region and PC wrap can be
//             observed alongside the main instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Jump = 1'b0, Branch = 1'b0, Zero = 1'b0, stall = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;

    logic        req_a, req_b, req_c;
    logic        iv_a, iv_b, iv_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [31:0] instr_a, instr_b, instr_c;
    logic [5:0]  op_a, op_b, op_c, fn_a, fn_b, fn_c;
    logic [31:0] pc_a, pc_b, pc_c, pc4_a, pc4_b, pc4_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;
    logic [31:0] last_instr = '0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h0000_3000)) u_dut_a (
        .clk(clk), .rst(rst), .Jump(Jump), .Branch(Branch), .Zero(Zero), .stall(stall),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .Instr(instr_a), .InstrValid(iv_a), .OpCode(op_a), .Funct(fn_a),
        .PC(pc_a), .PCPlus4(pc4_a), .InstrCount(cnt_a)
    );

    ifu #(.RESET_PC(32'hF000_0010)) u_dut_b (
        .clk(clk), .rst(rst), .Jump(Jump), .Branch(Branch), .Zero(Zero), .stall(stall),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .Instr(instr_b), .InstrValid(iv_b), .OpCode(op_b), .Funct(fn_b),
        .PC(pc_b), .PCPlus4(pc4_b), .InstrCount(cnt_b)
    );

    ifu #(.RESET_PC(32'hFFFF_FFFC)) u_dut_c (
        .clk(clk), .rst(rst), .Jump(Jump), .Branch(Branch), .Zero(Zero), .stall(stall),
        .imem_req(req_c), .imem_addr(addr_c), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .Instr(instr_c), .InstrValid(iv_c), .OpCode(op_c), .Funct(fn_c),
        .PC(pc_c), .PCPlus4(pc4_c), .InstrCount(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold rst for two cycles, then release and check the first FETCH cycle
    task automatic do_reset();
        rst = 1'b1; imem_valid = 1'b0; stall = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        chk("rst_req", {31'b0, req_a}, 32'd0);
        chk("rst_iv",  {31'b0, iv_a},  32'd0);
        tick();
        chk("rst_pc",    pc_a,    32'h0000_3000);
        chk("rst_instr", instr_a, 32'd0);
        chk("rst_cnt",   cnt_a,   32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req",  {31'b0, req_a}, 32'd1);
        chk("post_rst_addr", addr_a, 32'h0000_3000);
        exp_count  = 0;
        last_instr = '0;
    endtask

    // One instruction: `waits` empty FETCH cycles, the data beat, `stalls`
    // held EXEC cycles, then the retiring EXEC cycle with j/b/z applied.
    task automatic run_instr(input logic [31:0] w, input int waits, input int stalls,
                             input logic j, input logic b, input logic z,
                             input logic [31:0] pc, input logic [31:0] exp_next);
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            #1;
            chk("wait_req",   {31'b0, req_a}, 32'd1);
            chk("wait_addr",  addr_a,  pc);
            chk("wait_iv",    {31'b0, iv_a}, 32'd0);
            chk("wait_instr", instr_a, last_instr);
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        #1;
        chk("fetch_req",  {31'b0, req_a}, 32'd1);
        chk("fetch_addr", addr_a, pc);
        tick();
        imem_valid = 1'b0;
        chk("exec_iv",    {31'b0, iv_a}, 32'd1);
        chk("exec_req",   {31'b0, req_a}, 32'd0);
        chk("exec_instr", instr_a, w);
        chk("exec_op",    {26'b0, op_a}, {26'b0, w[31:26]});
        chk("exec_fn",    {26'b0, fn_a}, {26'b0, w[5:0]});
        chk("exec_pc4",   pc4_a, pc + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
            imem_valid = 1'b1;
            imem_rdata = 32'hBAD0_0BAD;
            tick();
            chk("stall_pc",    pc_a,    pc);
            chk("stall_instr", instr_a, w);
            chk("stall_cnt",   cnt_a,   exp_count);
            chk("stall_iv",    {31'b0, iv_a}, 32'd1);
        end
        stall = 1'b0;
        imem_valid = 1'b0;
        Jump = j; Branch = b; Zero = z;
        tick();
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        exp_count++;
        chk("next_pc",   pc_a,   exp_next);
        chk("next_addr", addr_a, exp_next);
        chk("next_cnt",  cnt_a,  exp_count);
        chk("next_iv",   {31'b0, iv_a}, 32'd0);
        chk("hold_op",   {26'b0, op_a}, {26'b0, w[31:26]});
        last_instr = w;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Zero-wait sequential fetch; instance c wraps past 0xFFFF_FFFC
        do_reset();
        run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3004);
        chk("wrap_pc_c", pc_c, 32'h0000_0000);
        chk("seq_pc_b",  pc_b, 32'hF000_0014);
        run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3008);
        chk("wrap_pc_c2", pc_c, 32'h0000_0004);

        // Three wait cycles, then a held EXEC for five cycles
        run_instr(32'h012A_4020, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h0000_300C);
        run_instr(32'h0231_8822, 0, 5, 1'b0, 1'b0, 1'b0, 32'h0000_300C, 32'h0000_3010);

        // Jump with Branch and Zero also set: jump target wins
        do_reset();
        run_instr({c_OP_J, 26'h000_0040}, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0100);
        chk("jump_pc_b", pc_b, 32'hF000_0100);
        chk("jump_pc_c", pc_c, 32'h0000_0100);

        // BEQ at 0x100 with imm -2: taken -> 0xFC, then back to 0x100, not taken -> 0x104
        run_instr({c_OP_BEQ, 10'h000, 16'hFFFE}, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_00FC);
        run_instr({c_OP_BEQ, 10'h000, 16'h0000}, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_00FC, 32'h0000_0100);
        run_instr({c_OP_BEQ, 10'h000, 16'hFFFE}, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0104);

        // Jump to 0x20, then reset while waiting in FETCH with a response present
        run_instr({c_OP_J, 26'h000_0008}, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0020);
        chk("pre_rst_cnt", cnt_a, 32'd5);
        rst = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        rst = 1'b0;
        imem_valid = 1'b0;
        #1;
        chk("midrst_pc",    pc_a,    32'h0000_3000);
        chk("midrst_cnt",   cnt_a,   32'd0);
        chk("midrst_iv",    {31'b0, iv_a}, 32'd0);
        chk("midrst_instr", instr_a, 32'd0);
        chk("midrst_req",   {31'b0, req_a}, 32'd1);
        exp_count  = 0;
        last_instr = '0;
        run_instr({c_OP_RTYPE, 20'h0, 6'h20}, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
